// File: rtl/ccg_equiv_sequencer.sv
// Stimulus-and-compare sequencer for A/B equivalence runs of 25-in/22-out netlists.
// Optional side-A MISR signature: define CCG_SEQ_MISR_EN.
module ccg_equiv_sequencer #(
  parameter int unsigned      IN_W      = 25,
  parameter int unsigned      OUT_W     = 22,
  parameter int unsigned      CNT_W     = 16,
  parameter int unsigned      SETTLE    = 1,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 25'h1200000,
  parameter logic [OUT_W-1:0] MISR_TAPS = 22'h300000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  dut_x,
  input  logic [OUT_W-1:0] dut_f_a,
  input  logic [OUT_W-1:0] dut_f_b,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] signature
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  x_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic             busy_d, done_d, fail_d;
  logic [CNT_W-1:0] mcnt_d, ffi_d;
  logic [IN_W-1:0]  ffv_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic             mis_c;

  assign mis_c = (dut_f_a != dut_f_b);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dut_x          <= '0;
      set_q          <= '0;
      idx_q          <= '0;
      nvec_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
      sig_q          <= '0;
    end else begin
      state_q        <= state_d;
      dut_x          <= x_d;
      set_q          <= set_d;
      idx_q          <= idx_d;
      nvec_q         <= nvec_d;
      busy           <= busy_d;
      done           <= done_d;
      fail           <= fail_d;
      mismatch_cnt   <= mcnt_d;
      first_fail_idx <= ffi_d;
      first_fail_vec <= ffv_d;
      sig_q          <= sig_d;
    end
  end

  // Next-state and datapath updates; abort overrides every state.
  always_comb begin
    state_d = state_q;
    x_d     = dut_x;
    set_d   = set_q;
    idx_d   = idx_q;
    nvec_d  = nvec_q;
    busy_d  = busy;
    done_d  = 1'b0;
    fail_d  = fail;
    mcnt_d  = mismatch_cnt;
    ffi_d   = first_fail_idx;
    ffv_d   = first_fail_vec;
    sig_d   = sig_q;

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_d    = (seed == '0) ? IN_W'(1) : seed;
            nvec_d = num_vec;
            idx_d  = '0;
            fail_d = 1'b0;
            mcnt_d = '0;
            ffi_d  = '0;
            ffv_d  = '0;
            sig_d  = '0;
            set_d  = SET_W'(SETTLE);
            busy_d = 1'b1;
            if (num_vec == '0)   state_d = S_DONE;
            else if (SETTLE == 0) state_d = S_CAPTURE;
            else                  state_d = S_SETTLE;
          end
        end

        S_SETTLE: begin
          set_d = set_q - SET_W'(1);
          if (set_q <= SET_W'(1)) state_d = S_CAPTURE;
        end

        S_CAPTURE: begin
          if (mis_c) begin
            if (mismatch_cnt != '1) mcnt_d = mismatch_cnt + CNT_W'(1);
            fail_d = 1'b1;
            if (!fail) begin
              ffi_d = idx_q;
              ffv_d = dut_x;
            end
          end
          sig_d = {sig_q[OUT_W-2:0], ^(sig_q & MISR_TAPS)} ^ dut_f_a;
          idx_d = idx_q + CNT_W'(1);
          if (idx_d == nvec_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d     = {dut_x[IN_W-2:0], ^(dut_x & LFSR_TAPS)};
            set_d   = SET_W'(SETTLE);
            state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
          end
        end

        S_DONE: begin
          // An empty run enters DONE still busy; it pulses done one cycle later.
          if (!done) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef CCG_SEQ_MISR_EN
  assign signature = sig_q;
`else
  // Constant zero; the signature register is left without a load.
  assign signature = MISR_TAPS & ~MISR_TAPS;
`endif

endmodule
